input_debouncer: RTL and testbench

Debounce and edge-event stage placed directly downstream of the two-flop synchronizer. It consumes the synchronized input (synchronizer `Q2`) and produces four outputs: a debounced level, single-cycle rise/fall strobes and a saturating count of debounced rising events. These outputs feed the health-indicator logic. The block filters contact bounce and metastability-resolved glitches shorter than `STABLE_CYCLES` clocks.

---
 rtl/input_debouncer.sv | 113 +++++++++++
 tb/tb_input_debouncer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debounce stage behind the input synchronizer. It produces a debounced level,
// one-cycle rise/fall strobes and a saturating count of debounced rises.
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sync_in,
    input  logic             clear_cnt,
    output logic             level,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [SW-1:0]    STAB_LAST = SW'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    state_t           state, state_n;
    logic [SW-1:0]    stab, stab_n;
    logic             level_n, rise_n, fall_n;
    logic [CNT_W-1:0] cnt_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= LOW;
            stab      <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            event_cnt <= '0;
        end else begin
            state     <= state_n;
            stab      <= stab_n;
            level     <= level_n;
            rise      <= rise_n;
            fall      <= fall_n;
            event_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        stab_n  = stab;
        level_n = level;
        rise_n  = 1'b0;
        fall_n  = 1'b0;
        case (state)
            LOW: begin
                if (sync_in) begin
                    state_n = WAIT_HIGH;
                    stab_n  = SW'(1);
                end
            end
            WAIT_HIGH: begin
                if (!sync_in) begin
                    state_n = LOW;
                    stab_n  = '0;
                end else if (stab == STAB_LAST) begin
                    state_n = HIGH;
                    level_n = 1'b1;
                    rise_n  = 1'b1;
                    stab_n  = '0;
                end else begin
                    stab_n = stab + SW'(1);
                end
            end
            HIGH: begin
                if (!sync_in) begin
                    state_n = WAIT_LOW;
                    stab_n  = SW'(1);
                end
            end
            WAIT_LOW: begin
                if (sync_in) begin
                    state_n = HIGH;
                    stab_n  = '0;
                end else if (stab == STAB_LAST) begin
                    state_n = LOW;
                    level_n = 1'b0;
                    fall_n  = 1'b1;
                    stab_n  = '0;
                end else begin
                    stab_n = stab + SW'(1);
                end
            end
            default: begin
                state_n = LOW;
                stab_n  = '0;
                level_n = 1'b0;
            end
        endcase
    end

    // Clear has priority over a coincident rise; the count sticks at all-ones.
    always_comb begin
        cnt_n = event_cnt;
        if (clear_cnt)
            cnt_n = '0;
        else if (rise_n && event_cnt != CNT_MAX)
            cnt_n = event_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: a sample-run model pushes expected
// outputs per driven sample; they are popped and compared after each edge.
module tb_input_debouncer;

    localparam int SC = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          sync_in;
    logic          clear_cnt;
    logic          level, rise, fall;
    logic [CW-1:0] event_cnt;

    input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .sync_in   (sync_in),
        .clear_cnt (clear_cnt),
        .level     (level),
        .rise      (rise),
        .fall      (fall),
        .event_cnt (event_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          level;
        logic          rise;
        logic          fall;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    bit   m_level;
    int   m_run;
    int   m_cnt;
    int   total  = 0;
    int   passed = 0;
    int   nfail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".level"}, 32'(level), 0);
        chk({tag, ".rise"}, 32'(rise), 0);
        chk({tag, ".fall"}, 32'(fall), 0);
        chk({tag, ".cnt"}, 32'(event_cnt), 0);
    endtask

    task automatic model_rst();
        m_level = 1'b0;
        m_run   = 0;
        m_cnt   = 0;
        sb.delete();
    endtask

    // Model: the level flips once SC consecutive samples differ from it.
    task automatic step(input logic s, input logic c);
        exp_t e;
        sync_in   = s;
        clear_cnt = c;
        e.rise = 1'b0;
        e.fall = 1'b0;
        if (s != m_level) begin
            m_run++;
            if (m_run == SC) begin
                m_level = s;
                m_run   = 0;
                if (s) e.rise = 1'b1;
                else   e.fall = 1'b1;
            end
        end else begin
            m_run = 0;
        end
        if (c) m_cnt = 0;
        else if (e.rise && m_cnt < (1 << CW) - 1) m_cnt++;
        e.level = m_level;
        e.cnt   = m_cnt[CW-1:0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk("level", 32'(level), 32'(e.level));
            chk("rise", 32'(rise), 32'(e.rise));
            chk("fall", 32'(fall), 32'(e.fall));
            chk("event_cnt", 32'(event_cnt), 32'(e.cnt));
        end
    endtask

    task automatic rise_cycle();
        repeat (SC) step(1'b1, 1'b0);
        repeat (SC) step(1'b0, 1'b0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        sync_in   = 1'b0;
        clear_cnt = 1'b0;
        model_rst();
        #12;
        chk_zero("por");
        @(negedge clk);
        reset = 1'b1;

        // clean rise, held for 10 samples
        repeat (10) step(1'b1, 1'b0);
        chk("clean_rise.cnt", 32'(event_cnt), 1);

        // glitches from HIGH: no fall
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("glitch_hi.level", 32'(level), 1);

        // clean fall
        repeat (SC) step(1'b0, 1'b0);
        chk("clean_fall.level", 32'(level), 0);
        chk("clean_fall.cnt", 32'(event_cnt), 1);

        // glitches from LOW: no rise
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("glitch_lo.cnt", 32'(event_cnt), 1);

        // reach level=1, event_cnt=5, then async reset mid-cycle
        repeat (3) rise_cycle();
        repeat (SC) step(1'b1, 1'b0);
        chk("pre_rst.cnt", 32'(event_cnt), 5);
        chk("pre_rst.level", 32'(level), 1);
        #3;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        model_rst();
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        sync_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // saturation
        repeat (17) rise_cycle();
        chk("sat.cnt", 32'(event_cnt), 15);

        // clear pulse
        step(1'b0, 1'b1);
        chk("clear.cnt", 32'(event_cnt), 0);

        // clear coincident with rise
        rise_cycle();
        repeat (SC - 1) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("clr_rise.rise", 32'(rise), 1);
        chk("clr_rise.cnt", 32'(event_cnt), 0);
        repeat (SC) step(1'b0, 1'b0);

        // reset during WAIT_HIGH discards the partial count
        repeat (2) step(1'b1, 1'b0);
        #3;
        reset = 1'b0;
        model_rst();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (SC - 1) step(1'b1, 1'b0);
        chk("mid_wait.level_pre", 32'(level), 0);
        step(1'b1, 1'b0);
        chk("mid_wait.level", 32'(level), 1);
        chk("mid_wait.cnt", 32'(event_cnt), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
